// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock divider controller and its counter core.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DIV_MIN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered divided clock and once-per-period enable pulse.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] n,
  output logic             clk_en_out,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] ratio_reg, ratio_next;
  logic             act_reg, act_next;
  logic             clk_en_reg, clk_en_next;
  logic             clk_out_reg, clk_out_next;
  logic             last_cnt;

  assign last_cnt = (cnt_reg == ratio_reg - CNT_W'(1));

  always_comb begin
    ratio_next = ratio_reg;
    cnt_next   = '0;
    act_next   = 1'b0;
    if (load) begin
      ratio_next = n;
      act_next   = 1'b1;
    end else if (run && act_reg) begin
      act_next = 1'b1;
      cnt_next = last_cnt ? '0 : cnt_reg + CNT_W'(1);
    end
    // Enable is precomputed from next-state so it lines up with cnt == N-1.
    clk_en_next  = act_next && (cnt_next == ratio_next - CNT_W'(1));
    clk_out_next = act_reg && (cnt_reg < (ratio_reg >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_reg     <= '0;
      ratio_reg   <= CNT_W'(DIV_MIN);
      act_reg     <= 1'b0;
      clk_en_reg  <= 1'b0;
      clk_out_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      ratio_reg   <= ratio_next;
      act_reg     <= act_next;
      clk_en_reg  <= clk_en_next;
      clk_out_reg <= clk_out_next;
    end
  end

  assign clk_en_out = clk_en_reg;
  assign clk_out    = clk_out_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// Configuration handshake and run/pending FSM driving the divider core;
// ratio changes are deferred to the period boundary so no period is cut short.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             clk_en_out,
  output logic             clk_out,
  output logic             busy
);

  state_t           state_reg, state_next;
  logic             pend_en_reg, pend_en_next;
  logic [CNT_W-1:0] pend_n_reg, pend_n_next;
  logic             cfg_ready_reg, busy_reg, cfg_err_reg;
  logic             xfer, bad_req;
  logic             core_load, core_run;
  logic [CNT_W-1:0] core_n;

  assign xfer    = cfg_valid && cfg_ready_reg;
  assign bad_req = cfg_en && (cfg_div < CNT_W'(DIV_MIN));

  always_comb begin
    state_next   = state_reg;
    pend_en_next = pend_en_reg;
    pend_n_next  = pend_n_reg;
    core_load    = 1'b0;
    core_run     = 1'b0;
    core_n       = cfg_div;
    case (state_reg)
      ST_IDLE: begin
        if (xfer && cfg_en && !bad_req) begin
          core_load  = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        if (xfer && !bad_req) begin
          pend_en_next = cfg_en;
          pend_n_next  = cfg_div;
          state_next   = ST_PEND;
        end
      end
      ST_PEND: begin
        core_run = 1'b1;
        // clk_en_out marks the last cycle of the current period.
        if (clk_en_out) begin
          if (pend_en_reg) begin
            core_load  = 1'b1;
            core_n     = pend_n_reg;
            state_next = ST_RUN;
          end else begin
            core_run   = 1'b0;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      pend_en_reg   <= 1'b0;
      pend_n_reg    <= '0;
      cfg_ready_reg <= 1'b0;
      busy_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_en_reg   <= pend_en_next;
      pend_n_reg    <= pend_n_next;
      cfg_ready_reg <= (state_next != ST_PEND);
      busy_reg      <= (state_next != ST_IDLE);
      cfg_err_reg   <= xfer && bad_req;
    end
  end

  assign cfg_ready = cfg_ready_reg;
  assign busy      = busy_reg;
  assign cfg_err   = cfg_err_reg;

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (core_load),
    .run       (core_run),
    .n         (core_n),
    .clk_en_out(clk_en_out),
    .clk_out   (clk_out)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized and directed bench for clk_div_ctrl against a cycle-level behavioural model.
module tb_clk_div_ctrl;

  localparam int W = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;

  logic         clk_in = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_en = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready, cfg_err, clk_en_out, clk_out, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_mode = M_IDLE;
  int m_phase = 0;
  int m_ratio = 2;
  bit m_pend_en = 0;
  int m_pend_n = 0;
  bit m_ready = 0;
  bit m_err = 0;
  bit m_clk_out = 0;

  always #5 clk_in = ~clk_in;

  clk_div_ctrl #(.CNT_W(W)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_en_out(clk_en_out),
    .clk_out   (clk_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference: divided period of m_ratio cycles,
  // high for the first floor(N/2) counts (seen one cycle later on clk_out).
  task automatic model_edge(input bit r, input bit v, input bit en, input int div);
    bit xfer, bad, at_end;
    xfer = v && m_ready;
    bad = en && (div < 2);
    at_end = (m_mode != M_IDLE) && (m_phase == m_ratio - 1);
    m_clk_out = (m_mode != M_IDLE) && (m_phase < m_ratio / 2);
    if (r) begin
      m_mode = M_IDLE; m_phase = 0; m_ratio = 2;
      m_pend_en = 0; m_pend_n = 0;
      m_ready = 0; m_err = 0; m_clk_out = 0;
      return;
    end
    m_err = xfer && bad;
    if (xfer)
      $display("xfer t=%0t en=%0d div=%0d mode=%0d %s", $time, en, div, m_mode,
               bad ? "rejected" : "accepted");
    case (m_mode)
      M_IDLE: begin
        if (xfer && en && !bad) begin
          m_ratio = div; m_phase = 0; m_mode = M_RUN;
        end
      end
      M_RUN: begin
        m_phase = at_end ? 0 : m_phase + 1;
        if (xfer && !bad) begin
          m_pend_en = en; m_pend_n = div; m_mode = M_PEND;
        end
      end
      default: begin
        if (at_end) begin
          m_phase = 0;
          if (m_pend_en) begin
            m_ratio = m_pend_n; m_mode = M_RUN;
          end else begin
            m_mode = M_IDLE;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
    endcase
    m_ready = (m_mode != M_PEND);
  endtask

  task automatic cycle(input bit r, input bit v, input bit en, input int div);
    rst = r;
    cfg_valid = v;
    cfg_en = en;
    cfg_div = W'(div);
    @(posedge clk_in);
    model_edge(r, v, en, div);
    @(negedge clk_in);
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_mode != M_IDLE));
    check("clk_en_out", 32'(clk_en_out), 32'((m_mode != M_IDLE) && (m_phase == m_ratio - 1)));
    check("clk_out", 32'(clk_out), 32'(m_clk_out));
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic request(input bit en, input int div);
    int guard;
    guard = 0;
    while (!m_ready && guard < 1000) begin
      cycle(0, 0, 0, 0);
      guard++;
    end
    if (guard >= 1000) check("ready_timeout", 0, 1);
    cycle(0, 1, en, div);
  endtask

  // Measure one full period from DUT outputs: length between enables and clk_out high time.
  task automatic measure_period(input string tag, input int exp_len, input int exp_hi);
    int guard, len, hi;
    guard = 0;
    while (clk_en_out !== 1'b1 && guard < 1000) begin
      cycle(0, 0, 0, 0);
      guard++;
    end
    len = 0;
    hi = 0;
    do begin
      cycle(0, 0, 0, 0);
      len++;
      if (clk_out === 1'b1) hi++;
    end while (clk_en_out !== 1'b1 && len < 1000);
    check({tag, "_len"}, 32'(len), 32'(exp_len));
    check({tag, "_hi"}, 32'(hi), 32'(exp_hi));
  endtask

  task automatic wait_model(input int mode, input int phase);
    int guard;
    guard = 0;
    while (!(m_mode == mode && m_phase == phase) && guard < 1000) begin
      cycle(0, 0, 0, 0);
      guard++;
    end
    if (guard >= 1000) check("wait_timeout", 0, 1);
  endtask

  initial begin
    int sel, div;
    bit v, en, r;

    // Reset held: outputs low, ready low
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 4);
    check("rst_ready", 32'(cfg_ready), 0);
    cycle(0, 0, 0, 0);
    check("post_rst_ready", 32'(cfg_ready), 1);

    // N=4 run
    request(1, 4);
    measure_period("n4", 4, 2);
    measure_period("n4b", 4, 2);

    // Rejected N=1 while running
    request(1, 1);
    check("rej_busy", 32'(busy), 1);
    idle_cycles(1);

    // Mid-period switch to N=7
    wait_model(M_RUN, 1);
    request(1, 7);
    check("pend_ready", 32'(cfg_ready), 0);
    measure_period("n7", 7, 3);

    // Switch to N=5, then stop
    request(1, 5);
    measure_period("n5", 5, 2);
    request(0, 3);
    wait_model(M_IDLE, 0);
    idle_cycles(10);
    check("idle_clk_out", 32'(clk_out), 0);
    check("idle_busy", 32'(busy), 0);

    // Reset during N=6 period while N=3 is pending
    request(1, 6);
    request(1, 3);
    wait_model(M_PEND, 2);
    cycle(1, 0, 0, 0);
    check("rst_mid_busy", 32'(busy), 0);
    idle_cycles(20);
    check("rst_no_pend", 32'(busy), 0);

    // N=2 and maximum ratio
    request(1, 2);
    measure_period("n2", 2, 1);
    request(1, 255);
    measure_period("n255", 255, 127);
    request(0, 0);
    wait_model(M_IDLE, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 2);
      en = ($urandom_range(0, 9) < 8);
      sel = $urandom_range(0, 9);
      if (sel < 2) div = sel;
      else if (sel == 2) div = 2;
      else if (sel == 3) div = 255;
      else div = $urandom_range(2, 12);
      cycle(r, v, en, div);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
